// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if -- handshake/operand bundle between the EX stage and div_ctrl.
//
// Signals (named from the divider's point of view):
//   start_i     : EX stage holds a divide/remainder instruction
//   signed_i    : 1 = DIV/REM (two's complement), 0 = DIVU/REMU
//   rem_i       : 1 = return remainder, 0 = return quotient
//   dividend_i  : rs1 value, sampled on acceptance only
//   divisor_i   : rs2 value, sampled on acceptance only
//   annul_i     : pipeline flush, aborts any operation
//   stallreq_o  : stall request to pipeline control
//   ready_o     : result valid this cycle
//   result_o    : quotient or remainder, zero when ready_o is low
//
// master = pipeline side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            signed_i;
    logic            rem_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            annul_i;
    logic            stallreq_o;
    logic            ready_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, signed_i, rem_i, dividend_i, divisor_i, annul_i,
        input  stallreq_o, ready_o, result_o
    );

    modport slave (
        input  start_i, signed_i, rem_i, dividend_i, divisor_i, annul_i,
        output stallreq_o, ready_o, result_o
    );
endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl -- multi-cycle restoring radix-2 divider for the EX stage.
//
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : div_ctrl_if.slave (start/operands/annul in, stall/ready/result out)
//
// Operation: an instruction is accepted in IDLE when start_i is high and
// annul_i is low. Divide-by-zero and signed overflow resolve immediately
// (one-cycle DONE). Everything else runs XLEN iterations in BUSY on operand
// magnitudes, then the recorded signs are applied on the way into DONE.
// DONE lasts one cycle and presents the selected result.
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    // Dividend bits leave from the MSB while quotient bits enter at the LSB.
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   prem;
    logic            neg_q;
    logic            neg_r;
    logic            rem_sel;
    logic [XLEN-1:0] result;

    // Acceptance and special-case decode.
    logic            accept;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;

    // One restoring iteration.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            q_bit;
    logic [XLEN:0]   prem_next;
    logic [XLEN-1:0] q_next;
    logic            last_iter;
    logic [XLEN-1:0] q_final;
    logic [XLEN-1:0] r_final;

    assign accept   = (state == IDLE) && bus.start_i && !bus.annul_i;
    assign div_zero = (bus.divisor_i == '0);
    assign overflow = bus.signed_i
                   && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.divisor_i == '1);

    // The most negative value maps to itself, which is the correct unsigned
    // magnitude, so no extra bit is needed.
    assign dividend_mag = (bus.signed_i && bus.dividend_i[XLEN-1]) ? -bus.dividend_i
                                                                   : bus.dividend_i;
    assign divisor_mag  = (bus.signed_i && bus.divisor_i[XLEN-1]) ? -bus.divisor_i
                                                                  : bus.divisor_i;

    // The partial remainder stays below the divisor, so XLEN+1 bits hold the
    // shifted value and the sign of the trial subtraction without truncation.
    assign shifted   = {prem[XLEN-1:0], dvd_q[XLEN-1]};
    assign trial     = shifted - {1'b0, dvs};
    assign q_bit     = ~trial[XLEN];
    assign prem_next = q_bit ? trial : shifted;
    assign q_next    = {dvd_q[XLEN-2:0], q_bit};
    assign last_iter = (cnt == CW'(XLEN - 1));
    assign q_final   = neg_q ? -q_next : q_next;
    assign r_final   = neg_r ? -prem_next[XLEN-1:0] : prem_next[XLEN-1:0];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; annul overrides both acceptance and completion.
    // NOTE: state_nxt gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (div_zero || overflow) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!bus.start_i) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (bus.annul_i) begin
            state_nxt = IDLE;
        end
    end

    // Datapath registers.
    // NOTE: the datapath is reset along with the FSM so every observable
    // register has a defined value straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            dvd_q   <= '0;
            dvs     <= '0;
            prem    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            rem_sel <= bus.rem_i;
            cnt     <= '0;
            if (div_zero) begin
                result <= bus.rem_i ? bus.dividend_i : '1;
            end else if (overflow) begin
                result <= bus.rem_i ? '0 : bus.dividend_i;
            end else begin
                dvd_q <= dividend_mag;
                dvs   <= divisor_mag;
                prem  <= '0;
                neg_q <= bus.signed_i && (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
                neg_r <= bus.signed_i && bus.dividend_i[XLEN-1];
            end
        end else if (state == BUSY) begin
            cnt   <= cnt + 1'b1;
            dvd_q <= q_next;
            prem  <= prem_next;
            if (last_iter) begin
                result <= rem_sel ? r_final : q_final;
            end
        end
    end

    // Outputs. The rst term keeps stallreq_o low during reset even if the
    // pipeline is still presenting start_i.
    assign bus.ready_o    = (state == DONE) && !bus.annul_i;
    assign bus.result_o   = bus.ready_o ? result : '0;
    assign bus.stallreq_o = rst && bus.start_i && !bus.ready_o && !bus.annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl -- self-checking bench for div_ctrl.
//
// A behavioural model (plain arithmetic plus a latency countdown) predicts
// ready_o/result_o/stallreq_o, and a compare process checks them on every
// falling edge. Directed runs additionally pin result values and latency to
// hand-computed literals.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    div_ctrl_if #(.XLEN(XLEN)) bus ();

    div_ctrl #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_special(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input bit sgn, input bit rem,
                                            input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
        if (sgn) return rem ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
        return rem ? (a % b) : (a / b);
    endfunction

    bit          m_pending;
    int          m_left;
    logic [31:0] m_val;

    // m_left = cycles still to wait before the result is visible.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pending = 1'b0;
            m_left    = 0;
            m_val     = '0;
        end else if (m_pending) begin
            if (m_left == 0 || bus.annul_i || !bus.start_i) m_pending = 1'b0;
            else m_left--;
        end else if (bus.start_i && !bus.annul_i) begin
            m_pending = 1'b1;
            m_val     = ref_div(bus.signed_i, bus.rem_i, bus.dividend_i, bus.divisor_i);
            m_left    = is_special(bus.signed_i, bus.dividend_i, bus.divisor_i) ? 0 : XLEN;
        end
    end

    always @(negedge clk) begin
        logic er;
        er = rst && m_pending && (m_left == 0) && !bus.annul_i;
        check("ready", 32'(bus.ready_o), 32'(er));
        check("result", bus.result_o, er ? m_val : 32'h0);
        check("stall", 32'(bus.stallreq_o), 32'(rst && bus.start_i && !er && !bus.annul_i));
        if (bus.ready_o) ready_pulses++;
    end

    // ---------------- directed runs ----------------
    // Called #1 after a rising edge; that cycle is cycle 0. Returns #1 after
    // the edge that ends the DONE cycle.
    task automatic run_div(input string name, input bit sgn, input bit rem,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_val, input int exp_lat, input bit keep_start);
        bit got;
        int k;
        got = 1'b0;
        k   = 0;
        bus.start_i    = 1'b1;
        bus.signed_i   = sgn;
        bus.rem_i      = rem;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        while (!got && k < 100) begin
            @(negedge clk);
            if (bus.ready_o) begin
                got = 1'b1;
                check({name, "_val"}, bus.result_o, exp_val);
                check({name, "_lat"}, 32'(k), 32'(exp_lat));
            end
            @(posedge clk);
            #1;
            if (k == 0 && !got) begin
                // Operands are ignored after acceptance.
                bus.dividend_i = $urandom;
                bus.divisor_i  = $urandom;
            end
            k++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready_o never rose within 100 cycles", name);
        end
        if (!keep_start) bus.start_i = 1'b0;
    endtask

    initial begin
        int pulses_before;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.annul_i    = 1'b0;

        // Reset: outputs zero and no stall even with start_i high.
        #2 bus.start_i = 1'b1;
        #10;
        check("rst_ready", 32'(bus.ready_o), 32'h0);
        check("rst_result", bus.result_o, 32'h0);
        check("rst_stall", 32'(bus.stallreq_o), 32'h0);
        bus.start_i = 1'b0;
        #11 rst = 1'b1;
        @(posedge clk);
        #1;

        run_div("u100_7_q", 0, 0, 32'd100, 32'd7, 32'd14, 33, 0);
        run_div("u100_7_r", 0, 1, 32'd100, 32'd7, 32'd2, 33, 0);
        run_div("s-7_2_q", 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_div("s-7_2_r", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_div("s7_-2_r", 1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
        run_div("s7_-2_q", 1, 0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        run_div("u5_0_q", 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_div("u5_0_r", 0, 1, 32'd5, 32'd0, 32'd5, 1, 0);
        run_div("s-100_0_r", 1, 1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1, 0);
        run_div("ovf_q", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_div("ovf_r", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
        run_div("s-1_-1_q", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 0);
        run_div("smin_1_q", 1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 33, 0);
        run_div("umax_16_q", 0, 0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33, 0);
        run_div("umax_16_r", 0, 1, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, 0);

        // Annul in BUSY cycle 10: no result, full-length retry afterwards.
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd3;
        repeat (10) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        pulses_before = ready_pulses;
        @(negedge clk);
        check("annul_stall", 32'(bus.stallreq_o), 32'h0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("annul_no_ready", 32'(ready_pulses), 32'(pulses_before));
        run_div("after_annul", 0, 0, 32'd1000, 32'd3, 32'd333, 33, 0);

        // Reset mid-BUSY between edges, then a fresh divide.
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'h0000_FFFF;
        bus.divisor_i  = 32'd7;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.ready_o), 32'h0);
        check("midrst_result", bus.result_o, 32'h0);
        check("midrst_stall", 32'(bus.stallreq_o), 32'h0);
        @(posedge clk);
        #3;
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_div("after_rst", 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);

        // Back-to-back: second op starts in the cycle after DONE (cycle 34).
        pulses_before = ready_pulses;
        run_div("b2b_20_3", 0, 0, 32'd20, 32'd3, 32'd6, 33, 1);
        run_div("b2b_9_4", 0, 0, 32'd9, 32'd4, 32'd2, 33, 0);
        check("b2b_pulses", 32'(ready_pulses - pulses_before), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
